// File: rtl/imem_access_ctrl_pkg.sv
// Shared definitions for the instruction-memory access controller: FSM states,
// requester identifiers and default geometry of the memory and interrupt area.
package imem_access_ctrl_pkg;

    localparam int IMEM_MEM_AW   = 20;
    localparam int IMEM_DATA_W   = 16;
    localparam int IMEM_INT_AREA = 32;
    localparam int NUM_REQ       = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD1  = 2'd2,
        ST_RD2  = 2'd3
    } state_e;

    // Bit positions in the request/grant vectors; lower index = higher priority.
    typedef enum logic [1:0] {
        REQ_LD  = 2'd0,
        REQ_IRQ = 2'd1,
        REQ_IF  = 2'd2
    } req_id_e;

    function automatic req_id_e gnt_to_id(input logic [NUM_REQ-1:0] gnt);
        req_id_e id;
        if (gnt[REQ_LD]) begin
            id = REQ_LD;
        end else if (gnt[REQ_IRQ]) begin
            id = REQ_IRQ;
        end else begin
            id = REQ_IF;
        end
        return id;
    endfunction

endpackage

// File: rtl/imem_access_ctrl_prio_arb.sv
// Combinational fixed-priority arbiter: bit 0 wins, masked requesters never win.
module imem_prio_arb
    import imem_access_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic [NUM_REQ-1:0] elig;

    assign elig  = req_i & ~mask_i;
    // Isolate the lowest set bit of the eligible vector.
    assign gnt_o = elig & (~elig + NUM_REQ'(1));

endmodule

// File: rtl/imem_access_ctrl.sv
// Shares the single-ported instruction memory between loader, interrupt unit and
// fetch stage; owns every memory strobe and the data-bus tri-state.
module imem_access_ctrl
    import imem_access_ctrl_pkg::*;
#(
    parameter int MEM_AW   = IMEM_MEM_AW,
    parameter int DATA_W   = IMEM_DATA_W,
    parameter int INT_AREA = IMEM_INT_AREA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req,
    input  logic [31:0]           ld_addr,
    input  logic [DATA_W-1:0]     ld_wdata,
    output logic                  ld_gnt,
    input  logic                  irq_req,
    input  logic [4:0]            irq_vec,
    output logic                  irq_done,
    output logic [2*DATA_W-1:0]   irq_rdata,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    input  logic                  if_len2,
    input  logic                  if_flush,
    output logic                  if_done,
    output logic [2*DATA_W-1:0]   if_rdata,
    output logic                  if_busy,
    output logic [31:0]           mem_addr,
    inout  wire logic [DATA_W-1:0] mem_data,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_cs
);

    // Wide enough for every {irq_vec,0} pair and for the whole interrupt area.
    localparam int IRQ_AW = ($clog2(INT_AREA) > 6) ? $clog2(INT_AREA) : 6;

    state_e               state_q, state_d;
    req_id_e              owner_q, owner_d;
    logic                 len2_q, len2_d;
    logic                 kill_q, kill_d;
    logic [MEM_AW-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    word0_q, word0_d;
    logic                 ld_gnt_q, ld_gnt_d;
    logic                 irq_done_q, irq_done_d;
    logic                 if_done_q, if_done_d;
    logic [2*DATA_W-1:0]  irq_rdata_q, irq_rdata_d;
    logic [2*DATA_W-1:0]  if_rdata_q, if_rdata_d;

    logic [NUM_REQ-1:0]   arb_req;
    logic [NUM_REQ-1:0]   arb_mask;
    logic [NUM_REQ-1:0]   arb_gnt;
    req_id_e              win_id;
    logic [IRQ_AW-1:0]    irq_wa;
    logic                 last_rd;
    logic [2*DATA_W-1:0]  rd_word;
    logic                 unused_addr_hi;

    assign unused_addr_hi = ^{ld_addr[31:MEM_AW], if_addr[31:MEM_AW]};

    // A flush in the arbitration cycle withdraws the fetch so another requester may win.
    assign arb_req[REQ_LD]   = ld_req;
    assign arb_req[REQ_IRQ]  = irq_req;
    assign arb_req[REQ_IF]   = if_req & ~if_flush;
    assign arb_mask[REQ_LD]  = ld_gnt_q;
    assign arb_mask[REQ_IRQ] = irq_done_q;
    assign arb_mask[REQ_IF]  = if_done_q;

    imem_prio_arb u_arb (
        .req_i  (arb_req),
        .mask_i (arb_mask),
        .gnt_o  (arb_gnt)
    );

    assign win_id = gnt_to_id(arb_gnt);
    assign irq_wa = IRQ_AW'({irq_vec, 1'b0});

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        len2_d      = len2_q;
        kill_d      = kill_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word0_d     = word0_q;
        ld_gnt_d    = 1'b0;
        irq_done_d  = 1'b0;
        if_done_d   = 1'b0;
        irq_rdata_d = irq_rdata_q;
        if_rdata_d  = if_rdata_q;
        last_rd     = 1'b0;
        rd_word     = '0;

        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    owner_d = win_id;
                    kill_d  = 1'b0;
                    case (win_id)
                        REQ_LD: begin
                            addr_d  = ld_addr[MEM_AW-1:0];
                            wdata_d = ld_wdata;
                            len2_d  = 1'b0;
                            state_d = ST_WR;
                        end
                        REQ_IRQ: begin
                            addr_d  = MEM_AW'(irq_wa);
                            len2_d  = 1'b1;
                            state_d = ST_RD1;
                        end
                        default: begin
                            addr_d  = if_addr[MEM_AW-1:0];
                            len2_d  = if_len2;
                            state_d = ST_RD1;
                        end
                    endcase
                end
            end
            ST_WR: begin
                ld_gnt_d = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_RD1: begin
                word0_d = mem_data;
                if (owner_q == REQ_IF && if_flush) begin
                    kill_d = 1'b1;
                end
                if (len2_q) begin
                    // Natural MEM_AW-bit overflow gives the 0xFFFFF -> 0 wrap.
                    addr_d  = addr_q + MEM_AW'(1);
                    state_d = ST_RD2;
                end else begin
                    last_rd = 1'b1;
                    rd_word = {mem_data, {DATA_W{1'b0}}};
                end
            end
            ST_RD2: begin
                last_rd = 1'b1;
                rd_word = {word0_q, mem_data};
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (last_rd) begin
            state_d = ST_IDLE;
            if (owner_q == REQ_IRQ) begin
                irq_done_d  = 1'b1;
                irq_rdata_d = rd_word;
            end else if (owner_q == REQ_IF && !kill_q && !if_flush) begin
                if_done_d  = 1'b1;
                if_rdata_d = rd_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= REQ_LD;
            len2_q      <= 1'b0;
            kill_q      <= 1'b0;
            addr_q      <= '0;
            ld_gnt_q    <= 1'b0;
            irq_done_q  <= 1'b0;
            if_done_q   <= 1'b0;
            irq_rdata_q <= '0;
            if_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            len2_q      <= len2_d;
            kill_q      <= kill_d;
            addr_q      <= addr_d;
            ld_gnt_q    <= ld_gnt_d;
            irq_done_q  <= irq_done_d;
            if_done_q   <= if_done_d;
            irq_rdata_q <= irq_rdata_d;
            if_rdata_q  <= if_rdata_d;
        end
    end

    // Write data and first read word are only meaningful inside an access.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
        word0_q <= word0_d;
    end

    assign mem_cs    = (state_q != ST_IDLE);
    assign mem_write = (state_q == ST_WR);
    assign mem_read  = (state_q == ST_RD1) || (state_q == ST_RD2);
    assign mem_addr  = {{(32-MEM_AW){1'b0}}, addr_q};
    assign mem_data  = (state_q == ST_WR) ? wdata_q : {DATA_W{1'bz}};

    assign ld_gnt    = ld_gnt_q;
    assign irq_done  = irq_done_q;
    assign irq_rdata = irq_rdata_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign if_busy   = if_req & ~if_done_q & ~rst;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Bench for imem_access_ctrl: memory bus model, shadow-memory reference and
// directed plus randomized access sequences.
module tb_imem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [15:0] ld_wdata = '0;
    logic        ld_gnt;
    logic        irq_req = 1'b0;
    logic [4:0]  irq_vec = '0;
    logic        irq_done;
    logic [31:0] irq_rdata;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_len2 = 1'b0;
    logic        if_flush = 1'b0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_busy;
    logic [31:0] mem_addr;
    wire  [15:0] mem_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_cs;

    bit [15:0]   bfm_mem [1048576];
    bit [15:0]   ref_mem [1048576];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_if_exp = '0;

    imem_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_done  (irq_done),
        .irq_rdata (irq_rdata),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_len2   (if_len2),
        .if_flush  (if_flush),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .if_busy   (if_busy),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_cs    (mem_cs)
    );

    always #5 clk = ~clk;

    // Asynchronous-read, clocked-write memory on the shared bus.
    assign mem_data = (mem_cs && mem_read && !mem_write) ? bfm_mem[mem_addr[19:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (mem_cs && mem_write) bfm_mem[mem_addr[19:0]] <= mem_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, input bit two);
        int unsigned w0;
        int unsigned w1;
        w0 = a % 1048576;
        w1 = (w0 + 1) % 1048576;
        return {ref_mem[w0], two ? ref_mem[w1] : 16'h0000};
    endfunction

    function automatic logic pulse_of(input int which);
        case (which)
            0:       return ld_gnt;
            1:       return irq_done;
            default: return if_done;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("bus_rw_excl", {31'b0, mem_read & mem_write}, 32'd0);
            check("bus_cs", {31'b0, mem_cs}, {31'b0, mem_read | mem_write});
            check("bus_addr_hi", {20'b0, mem_addr[31:20]}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0 loader write, 1 irq read (a = vector word address), 2 fetch.
    task automatic run_access(input string tag, input int which, input logic [31:0] a,
                              input bit two, input logic [15:0] d);
        int          k;
        bit          seen;
        int          exp_lat;
        int unsigned w0;
        logic [31:0] exp_data;
        logic [2:0]  others;
        w0       = a % 1048576;
        exp_lat  = two ? 3 : 2;
        exp_data = ref_read(a, two);
        case (which)
            0: begin ld_addr = a; ld_wdata = d; ld_req = 1'b1; end
            1: begin irq_vec = a[5:1]; irq_req = 1'b1; end
            default: begin if_addr = a; if_len2 = two; if_req = 1'b1; end
        endcase
        k = 0;
        seen = 1'b0;
        while (!seen && k < 8) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_strobe1"}, {29'b0, mem_cs, mem_write, mem_read},
                      (which == 0) ? 32'h6 : 32'h5);
                check({tag, "_addr1"}, mem_addr, w0);
                if (which == 0) check({tag, "_wdata"}, {16'b0, mem_data}, {16'b0, d});
            end
            if (k == 2 && two) begin
                check({tag, "_strobe2"}, {29'b0, mem_cs, mem_write, mem_read}, 32'h5);
                check({tag, "_addr2"}, mem_addr, (w0 + 1) % 1048576);
            end
            if (which == 2) check({tag, "_busy"}, {31'b0, if_busy}, {31'b0, k != exp_lat});
            others = {if_done, irq_done, ld_gnt};
            others[which] = 1'b0;
            check({tag, "_other_pulse"}, {29'b0, others}, 32'd0);
            seen = pulse_of(which);
            if (!seen) k++;
        end
        check({tag, "_lat"}, seen ? k : -1, exp_lat);
        if (which == 1) check({tag, "_irq_rdata"}, irq_rdata, exp_data);
        if (which == 2) begin
            check({tag, "_if_rdata"}, if_rdata, exp_data);
            last_if_exp = exp_data;
        end
        step();
        ld_req  = 1'b0;
        irq_req = 1'b0;
        if_req  = 1'b0;
        if (which == 0) ref_mem[w0] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ld_k, irq_k, if_k, n_ld, n_irq, n_if, nd, ncs;
        bit          dl, di, df;
        logic [31:0] a, lo, exp_irq;
        int          kind;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pulses", {29'b0, ld_gnt, irq_done, if_done}, 32'd0);
        check("rst_strobes", {29'b0, mem_cs, mem_read, mem_write}, 32'd0);
        check("rst_busy", {31'b0, if_busy}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_irq_rdata", irq_rdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        // Write then read back
        run_access("wr40", 0, 32'h0000_0040, 1'b0, 16'hA5A5);
        run_access("rd40", 2, 32'h0000_0040, 1'b0, 16'h0000);
        check("plan_rd40", if_rdata, 32'hA5A5_0000);

        // Two-word fetch across the top of memory
        run_access("wrtop", 0, 32'h000F_FFFF, 1'b0, 16'h1234);
        run_access("wrzero", 0, 32'h0000_0000, 1'b0, 16'h5678);
        run_access("rdwrap", 2, 32'h000F_FFFF, 1'b1, 16'h0000);
        check("plan_wrap", if_rdata, 32'h1234_5678);

        // All three requesters in the same idle cycle
        run_access("pre6", 0, 32'd6, 1'b0, 16'($urandom));
        run_access("pre7", 0, 32'd7, 1'b0, 16'($urandom));
        exp_irq = ref_read(32'd6, 1'b1);
        ld_addr = 32'h100; ld_wdata = 16'hBEEF; ld_req = 1'b1;
        irq_vec = 5'd3; irq_req = 1'b1;
        if_addr = 32'h100; if_len2 = 1'b0; if_req = 1'b1;
        ref_mem[32'h100] = 16'hBEEF;
        ld_k = -1; irq_k = -1; if_k = -1; n_ld = 0; n_irq = 0; n_if = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("sim_busy", {31'b0, if_busy}, {31'b0, k < 7});
            dl = ld_gnt; di = irq_done; df = if_done;
            if (dl) begin n_ld++; ld_k = k; end
            if (di) begin n_irq++; irq_k = k; end
            if (df) begin n_if++; if_k = k; end
            step();
            if (dl) ld_req = 1'b0;
            if (di) irq_req = 1'b0;
            if (df) if_req = 1'b0;
        end
        check("sim_ld_cycle", ld_k, 2);
        check("sim_irq_cycle", irq_k, 2 + 3);
        check("sim_if_cycle", if_k, 2 + 3 + 2);
        check("sim_pulse_counts", {n_ld[7:0], n_irq[7:0], n_if[7:0]}, 32'h010101);
        check("sim_irq_rdata", irq_rdata, exp_irq);
        check("sim_if_rdata", if_rdata, 32'hBEEF_0000);
        last_if_exp = 32'hBEEF_0000;

        // Flush during RD1 and during RD2 of a two-word fetch
        for (int fc = 1; fc <= 2; fc++) begin
            if_addr = 32'h40 + fc; if_len2 = 1'b1; if_req = 1'b1;
            nd = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (if_done) nd++;
                step();
                if (c + 1 == fc) begin
                    if_flush = 1'b1;
                    if_req   = 1'b0;
                end else begin
                    if_flush = 1'b0;
                end
            end
            check("flush_no_done", nd, 0);
            check("flush_rdata_hold", if_rdata, last_if_exp);
            run_access("after_flush", 2, 32'h40 + fc, 1'b1, 16'h0000);
        end

        // Flush in the same cycle as the fetch would be granted
        if_addr = 32'h41; if_len2 = 1'b0; if_req = 1'b1; if_flush = 1'b1;
        nd = 0; ncs = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (if_done) nd++;
            if (mem_cs) ncs++;
            step();
            if_req = 1'b0;
            if_flush = 1'b0;
        end
        check("flush_grant_no_done", nd, 0);
        check("flush_grant_no_access", ncs, 0);

        // Randomized traffic against the shadow memory
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 2))
                0:       lo = $urandom_range(0, 31);
                1:       lo = 32'h40 + $urandom_range(0, 31);
                default: lo = 32'hFFFE0 + $urandom_range(0, 31);
            endcase
            a = ($urandom & 32'hFFF0_0000) | lo;
            kind = $urandom_range(0, 3);
            case (kind)
                0: run_access("rnd_wr", 0, a, 1'b0, 16'($urandom));
                1: run_access("rnd_irq", 1, 32'($urandom_range(0, 15)) * 2, 1'b1, 16'h0000);
                2: run_access("rnd_rd1", 2, a, 1'b0, 16'h0000);
                default: run_access("rnd_rd2", 2, a, 1'b1, 16'h0000);
            endcase
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset during RD1 of an interrupt vector read
        run_access("pre10", 0, 32'd10, 1'b0, 16'($urandom) | 16'h0001);
        run_access("pre11", 0, 32'd11, 1'b0, 16'($urandom));
        run_access("irq5", 1, 32'd10, 1'b1, 16'h0000);
        irq_vec = 5'd5; irq_req = 1'b1;
        step();
        @(negedge clk);
        check("rstmid_in_rd1", {29'b0, mem_cs, mem_read, mem_write}, 32'h6);
        rst = 1'b1;
        irq_req = 1'b0;
        step();
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (irq_done) nd++;
            check("rstmid_strobes", {29'b0, mem_cs, mem_read, mem_write}, 32'd0);
            step();
        end
        check("rstmid_no_irq_done", nd, 0);
        check("rstmid_irq_rdata", irq_rdata, 32'd0);
        check("rstmid_if_rdata", if_rdata, 32'd0);
        last_if_exp = '0;
        run_access("post_rst_rd", 2, 32'h0000_000A, 1'b1, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
- Sequences and shares the single-ported 16-bit instruction memory (1M words, bidirectional data bus, read/write/chip-select) between three requesters.
- Requesters: program loader (word writes), interrupt unit (2-word vector reads from the interrupt area), and fetch stage (1- or 2-word instruction reads).
- Sits between the fetch stage, interrupt logic and loader on one side and the instruction memory on the other.
- Owns all memory control strobes and the data-bus tri-state.

Parameters:
- MEM_AW, 20, memory word-address width; upper address bits are forced to zero on mem_addr.
- DATA_W, 16, memory word width.
- INT_AREA, 32, number of words in the interrupt area (word addresses 0..INT_AREA-1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_req  in  1  loader write request (level; held until ld_gnt).
- ld_addr  in  32  loader word address.
- ld_wdata  in  16  loader write data.
- ld_gnt  out  1  1-cycle pulse: write completed.
- irq_req  in  1  interrupt vector read request (level).
- irq_vec  in  5  vector index; words read at {irq_vec,1'b0} and +1.
- irq_done  out  1  1-cycle pulse: irq_rdata valid.
- irq_rdata  out  32  vector, first word in [31:16].
- if_req  in  1  fetch read request (level).
- if_addr  in  32  fetch word address.
- if_len2  in  1  1 = read 2 words; 0 = 1 word.
- if_flush  in  1  1-cycle pulse: cancel the outstanding fetch.
- if_done  out  1  1-cycle pulse: if_rdata valid.
- if_rdata  out  32  first word in [31:16]; second word in [15:0] (zero when if_len2 = 0).
- if_busy  out  1  fetch request pending and not yet done (stall source).
- mem_addr  out  32  memory address.
- mem_data  inout  16  memory data bus.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_cs  out  1  memory chip select.

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE; all strobes, pulses and if_busy go to 0; irq_rdata and if_rdata go to 0; mem_addr goes to 0; mem_data is released to Z.
  - Reset mid-access aborts that access with no done/gnt pulse.
- FSM states:
  - IDLE: arbitrate; latch the winner's operands.
  - WR: mem_cs = 1, mem_write = 1, mem_data driven with the latched data; next state IDLE; ld_gnt pulses in the following cycle.
  - RD1: mem_cs = 1, mem_read = 1, address = latched address; capture mem_data at the edge into word 0. Next state is RD2 if the access is 2 words, else IDLE.
  - RD2: same strobes at latched address + 1, wrapping modulo 2^MEM_AW (0xFFFFF -> 0x00000); capture into word 1; next state IDLE.
  - Done pulse for a read: registered, asserted in the first IDLE cycle after the last RDx.
- Latency from request seen in IDLE to pulse:
  - write: 2 cycles
  - 1-word read: 2 cycles
  - 2-word read: 3 cycles
- Arbitration priority: fixed, ld > irq > if.
  - Arbitration only happens in IDLE; a granted access is never preempted.
  - A requester whose done/gnt pulse is high in the current cycle is excluded from that cycle's arbitration, so requesters drop req the cycle after their pulse.
- Strobe rules:
  - mem_read and mem_write are never both 1.
  - mem_data is Z in every state except WR.
  - mem_cs = 0 in IDLE.
- irq address: the vector address is a word address below INT_AREA by construction; mem_addr[31:MEM_AW] = 0 always.
- Fetch flush:
  - if_flush while fetch is queued but not granted: the request is dropped; the fetcher re-requests.
  - if_flush during RD1/RD2 of a fetch: the access completes, but if_done is suppressed and if_rdata is not updated.
  - if_flush and a fetch grant in the same IDLE cycle: the grant is cancelled and another requester may win.
- if_busy = if_req & ~if_done.
- Output hold: rdata outputs hold their value until the next done for the same requester.

Decomposition:
- Shared package/include: FSM state encodings (IDLE, WR, RD1, RD2), requester IDs (REQ_LD, REQ_IRQ, REQ_IF), INT_AREA and MEM_AW constants.
- One natural sub-module, imem_prio_arb: a combinational 3-way fixed-priority arbiter with a per-requester mask input (the done-cycle exclusion), producing a one-hot grant.

Test Plan:
- Write then read: ld 0x00040 <- 0xA5A5, then fetch 0x00040 with if_len2 = 0 -> ld_gnt 2 cycles after request; if_done 2 cycles after; if_rdata = 0xA5A50000.
- 2-word fetch with wrap: preload 0xFFFFF = 0x1234 and 0x00000 = 0x5678; fetch 0xFFFFF with if_len2 = 1 -> mem_addr 0xFFFFF then 0x00000; if_rdata = 0x12345678 at 3 cycles.
- Simultaneous requests: ld, irq (vec 3) and if all asserted in the same IDLE cycle -> order WR, then irq reads at 6 and 7, then fetch. Each requester gets exactly one pulse, and if_busy stays 1 until if_done.
- Flush during RD2 of a 2-word fetch -> no if_done; if_rdata unchanged; next fetch proceeds normally.
- Sync reset asserted during RD1 of an irq read -> next cycle all strobes 0, mem_data Z, irq_done never pulses, irq_rdata = 0.
- Bus check across all scenarios: mem_read & mem_write never both 1; mem_data is Z whenever mem_write = 0.
